// File: rtl/imem_loader_if.sv
// Byte-stream handshake bundle feeding the instruction-memory loader.
// Ports: in_data[7:0], in_valid (source->loader), in_ready (loader->source).
interface imem_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );
endinterface

// File: rtl/imem_loader.sv
// Packs a length-prefixed byte stream into 32-bit LE words and writes imem.
// Ports: clk, rst (async active-low), start, strm (byte stream slave),
//   imem_we/imem_waddr/imem_wdata (registered write port),
//   busy, done, err, word_cnt (load status).
module imem_loader #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   imem_loader_if.slave        strm,
   output logic                imem_we,
   output logic [31:0]         imem_waddr,
   output logic [31:0]         imem_wdata,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [15:0]         word_cnt
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LEN_LO = 3'd1;
   localparam logic [2:0] LEN_HI = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] WRITE  = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [2:0] ERR    = 3'd6;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   logic [2:0]  state;
   logic [15:0] len;
   logic [1:0]  byte_idx;
   logic [23:0] word_q;
   logic        xfer;
   logic [15:0] len_full;
   logic [15:0] cnt_next;

   assign strm.in_ready = (state == LEN_LO) ||
                          (state == LEN_HI) ||
                          (state == DATA);
   assign xfer     = strm.in_valid && strm.in_ready;
   assign len_full = {strm.in_data, len[7:0]};
   assign cnt_next = word_cnt + 16'd1;

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      err  = 1'b0;
      case (state)
         LEN_LO, LEN_HI,
         DATA, WRITE:    busy = 1'b1;
         DONE:           done = 1'b1;
         ERR:            err  = 1'b1;
         default:        busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         len        <= '0;
         byte_idx   <= '0;
         word_q     <= '0;
         word_cnt   <= '0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state    <= LEN_LO;
                  len      <= '0;
                  byte_idx <= '0;
                  word_q   <= '0;
                  word_cnt <= '0;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len[7:0] <= strm.in_data;
                  state    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len[15:8] <= strm.in_data;
                  byte_idx  <= '0;
                  if (len_full == 16'd0)
                     state <= DONE;
                  else if ({1'b0, len_full} > DEPTH_W)
                     state <= ERR;
                  else
                     state <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_q[7:0]   <= strm.in_data;
                     2'd1: word_q[15:8]  <= strm.in_data;
                     2'd2: word_q[23:16] <= strm.in_data;
                     default: begin
                        // Last byte goes straight into the output
                        // register so the write lands next cycle.
                        imem_we    <= 1'b1;
                        imem_waddr <= BASE_ADDR +
                                      {14'd0, word_cnt, 2'b00};
                        imem_wdata <= {strm.in_data, word_q};
                        state      <= WRITE;
                     end
                  endcase
               end
            end
            WRITE: begin
               word_cnt <= cnt_next;
               if (cnt_next == len)
                  state <= DONE;
               else
                  state <= DATA;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Model: expected writes derived from the word image and length rules.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] word_cnt;

   imem_loader_if strm();

   imem_loader #(
      .DEPTH     (256),
      .BASE_ADDR (32'h0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .strm       (strm),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   logic [31:0] img[$];
   logic [31:0] got_a[$];
   logic [31:0] got_d[$];

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         got_a.push_back(imem_waddr);
         got_d.push_back(imem_wdata);
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit drop);
      int n;
      bit rdy;
      n = 0;
      if (drop) begin
         while ($urandom_range(1, 0) == 1 && n < 8) begin
            strm.in_valid = 1'b0;
            strm.in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
         end
      end
      strm.in_data  = b;
      strm.in_valid = 1'b1;
      n = 0;
      do begin
         rdy = strm.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 40);
      strm.in_valid = 1'b0;
      if (!rdy) begin
         checks++;
         $display("FAIL send_timeout: byte %h in_ready=0 for %0d cycles, want 1",
                  b, n);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Streams len + img words and checks the resulting writes and status.
   task automatic run_load(input logic [15:0] len, input bit drop,
                           input string tag);
      bit exp_err;
      int nw;
      int n;
      int exp_lat;
      exp_err = (len > 16'd256);
      nw      = exp_err ? 0 : int'(len);
      exp_lat = (nw > 0) ? 1 : 0;
      got_a.delete();
      got_d.delete();
      pulse_start();
      checks++;
      if ({busy, done, err, word_cnt} !== {3'b100, 16'd0})
         $display("FAIL %s_start: busy/done/err/cnt=%b%b%b/%0d want 100/0",
                  tag, busy, done, err, word_cnt);
      else passed++;
      send_byte(len[7:0], drop);
      send_byte(len[15:8], drop);
      for (int i = 0; i < nw; i++)
         for (int k = 0; k < 4; k++)
            send_byte(8'(img[i] >> (8 * k)), drop);
      n = 0;
      while (!(done || err) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n !== exp_lat)
         $display("FAIL %s_latency: got %0d cycles want %0d", tag, n, exp_lat);
      else passed++;
      checks++;
      if ({done, err, busy} !== {!exp_err, exp_err, 1'b0})
         $display("FAIL %s_status: done/err/busy=%b%b%b want %b%b0",
                  tag, done, err, busy, !exp_err, exp_err);
      else passed++;
      checks++;
      if (word_cnt !== 16'(nw))
         $display("FAIL %s_word_cnt: got %0d want %0d", tag, word_cnt, nw);
      else passed++;
      strm.in_valid = 1'b1;
      strm.in_data  = 8'hA5;
      #1;
      checks++;
      if (strm.in_ready !== 1'b0)
         $display("FAIL %s_ready_after: got %b want 0", tag, strm.in_ready);
      else passed++;
      @(posedge clk);
      #1;
      strm.in_valid = 1'b0;
      checks++;
      if (got_a.size() !== nw)
         $display("FAIL %s_nwrites: got %0d want %0d", tag, got_a.size(), nw);
      else passed++;
      for (int i = 0; i < nw && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== 32'(4 * i) || got_d[i] !== img[i])
            $display("FAIL %s_write%0d: got %h@%h want %h@%h",
                     tag, i, got_d[i], got_a[i], img[i], 32'(4 * i));
         else passed++;
      end
   endtask

   task automatic load_test2_image();
      img.delete();
      img.push_back(32'h00200533);
      img.push_back(32'h003105B3);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      strm.in_valid = 1'b0;
      strm.in_data  = 8'h00;
      #12;
      checks++;
      if ({imem_we, imem_waddr, imem_wdata, busy, done, err,
           word_cnt, strm.in_ready} !== '0)
         $display("FAIL reset_outputs: we=%b a=%h d=%h b/d/e=%b%b%b cnt=%0d rdy=%b want all 0",
                  imem_we, imem_waddr, imem_wdata, busy, done, err,
                  word_cnt, strm.in_ready);
      else passed++;
      rst = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      strm.in_valid = 1'b1;
      #1;
      checks++;
      if (strm.in_ready !== 1'b0)
         $display("FAIL idle_ready: got %b want 0", strm.in_ready);
      else passed++;
      strm.in_valid = 1'b0;
   endtask

   task automatic test_basic();
      load_test2_image();
      run_load(16'd2, 1'b0, "basic");
      checks++;
      if (got_d.size() < 2 || got_d[0] !== 32'h00200533 ||
          got_d[1] !== 32'h003105B3)
         $display("FAIL basic_literal: got %0d words, want 00200533,003105b3",
                  got_d.size());
      else passed++;
   endtask

   task automatic test_zero_len();
      img.delete();
      run_load(16'd0, 1'b0, "zero");
   endtask

   task automatic test_err();
      img.delete();
      run_load(16'h0101, 1'b0, "err");
      img.push_back($urandom);
      run_load(16'd1, 1'b0, "after_err");
   endtask

   task automatic test_drop();
      load_test2_image();
      run_load(16'd2, 1'b1, "drop");
      for (int t = 0; t < 4; t++) begin
         int len;
         len = $urandom_range(6, 1);
         img.delete();
         for (int i = 0; i < len; i++) img.push_back($urandom);
         run_load(16'(len), 1'b1, "rand");
      end
   endtask

   task automatic test_full_depth();
      img.delete();
      for (int i = 0; i < 256; i++) img.push_back($urandom);
      run_load(16'd256, 1'b0, "depth");
   endtask

   task automatic test_start_busy();
      got_a.delete();
      got_d.delete();
      pulse_start();
      send_byte(8'h01, 1'b0);
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h78, 1'b0);
      pulse_start();
      send_byte(8'h56, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || got_d.size() !== 1 ||
          (got_d.size() == 1 && got_d[0] !== 32'h12345678))
         $display("FAIL start_busy: done=%b nwrites=%0d want done=1, one write 12345678",
                  done, got_d.size());
      else passed++;
   endtask

   task automatic test_mid_reset();
      got_a.delete();
      got_d.delete();
      pulse_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h00, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({imem_we, imem_waddr, imem_wdata, busy, done, err,
           word_cnt, strm.in_ready} !== '0)
         $display("FAIL midreset_outputs: we=%b a=%h d=%h b/d/e=%b%b%b cnt=%0d want all 0",
                  imem_we, imem_waddr, imem_wdata, busy, done, err, word_cnt);
      else passed++;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (got_a.size() !== 1 || (got_a.size() == 1 && got_a[0] !== 32'h0))
         $display("FAIL midreset_writes: got %0d writes want 1 @0",
                  got_a.size());
      else passed++;
      rst = 1'b1;
      @(posedge clk);
      #1;
      load_test2_image();
      run_load(16'd2, 1'b0, "rerun");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_err();
      test_drop();
      test_start_busy();
      test_full_depth();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
